// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1-style serial receiver driven by an external oversampling tick.
//   clk_in        system clock, rising edge
//   rst_in        asynchronous active-high reset
//   divpulse_in   one-cycle tick at OVERSAMPLING_RATE x baud (may be held high: one tick per clock)
//   rx_in         asynchronous serial line, idle high
//   data_out      last good word (LSB first on the line)
//   valid_out     one-cycle pulse when data_out updates
//   frame_err_out one-cycle pulse on a bad stop bit
//   busy_out      high whenever the receiver is not idle
// Optional: define UART_RX_MAJORITY_EN for a three-tick majority vote on every bit decision.
module uart_rx #(
  parameter int OVERSAMPLING_RATE = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 divpulse_in,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 frame_err_out,
  output logic                 busy_out
);
  localparam int TW = $clog2(OVERSAMPLING_RATE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLING_RATE - 1);
  // tick_cnt value on the tick that brings it to OVERSAMPLING_RATE/2
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLING_RATE / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
  // Every decision moves one tick later so the vote window straddles the nominal sample tick.
  localparam logic [TW-1:0] T_FIRST = '0;
`else
  localparam logic [TW-1:0] T_FIRST = TW'(1);
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sr_q, sr_d, data_q, data_d;
  logic                 valid_q, valid_d, ferr_q, ferr_d;
  logic                 rx_s, smp, wrap;

  assign rx_s = sync_q[1];
  assign wrap = tick_q == T_LAST;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) hist_q <= 2'b11;
    else if (divpulse_in) hist_q <= {hist_q[0], rx_s};
  assign smp = (hist_q[0] & hist_q[1]) | (hist_q[0] & rx_s) | (hist_q[1] & rx_s);
`else
  assign smp = rx_s;
`endif

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (divpulse_in) begin
      tick_d = wrap ? '0 : tick_q + 1'b1;
      case (state_q)
        IDLE: begin
          tick_d  = rx_s ? '0 : T_FIRST;
          state_d = rx_s ? IDLE : START;
        end
        START:
          if (tick_q == T_MID) begin
            state_d = smp ? IDLE : DATA;
            tick_d  = '0;
            bit_d   = '0;
          end
        DATA:
          if (wrap) begin
            sr_d    = {smp, sr_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            state_d = (bit_q == B_LAST) ? STOP : DATA;
          end
        STOP:
          if (wrap) begin
            state_d = smp ? IDLE : WAIT_IDLE;
            valid_d = smp;
            ferr_d  = !smp;
            data_d  = smp ? sr_q : data_q;
          end
        WAIT_IDLE: begin
          tick_d  = '0;
          state_d = rx_s ? IDLE : WAIT_IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      tick_q  <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rx_in};
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end

  assign data_out      = data_q;
  assign valid_out     = valid_q;
  assign frame_err_out = ferr_q;
  assign busy_out      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with the tick held high (8 clocks per bit).
module tb_uart_rx;
  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       divpulse_in = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] data_out;
  logic       valid_out, frame_err_out, busy_out;

  typedef struct {logic err; logic [7:0] data;} exp_t;
  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_v = 0;
  int prev_v = 0;

  uart_rx dut (
    .clk_in(clk_in), .rst_in(rst_in), .divpulse_in(divpulse_in), .rx_in(rx_in),
    .data_out(data_out), .valid_out(valid_out), .frame_err_out(frame_err_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk_in) begin
    if (valid_out && frame_err_out) check("valid_and_err_together", 1, 0);
    if (valid_out || frame_err_out) begin
      if (exp_q.size() == 0) check("unexpected_pulse", {valid_out, frame_err_out}, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind_err", frame_err_out, e.err);
        check("data_out", data_out, e.data);
      end
      if (valid_out) begin
        prev_v = last_v;
        last_v = cyc;
      end
    end
  end

  task automatic drive(input logic v, input int n);
    rx_in = v;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input int stop_len, input int gbit);
    drive(1'b0, 8);
    for (int k = 0; k < 8; k++)
      if (k == gbit) begin
        drive(d[k], 3);
        drive(~d[k], 1);
        drive(d[k], 4);
      end else drive(d[k], 8);
    drive(stop, stop_len);
    rx_in = 1'b1;
  endtask

  task automatic expect_word(input logic err, input logic [7:0] d);
    exp_t e;
    e.err = err;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk_in);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] glitch_exp;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    check("reset_data", data_out, 0);
    check("reset_valid", valid_out, 0);
    check("reset_err", frame_err_out, 0);
    check("reset_busy", busy_out, 0);
    drive(1'b1, 4);
    expect_word(1'b0, 8'hA5);
    send(8'hA5, 1'b1, 8, -1);
    drive(1'b1, 8);
    drain("drain_a5");
    drive(1'b0, 2);
    drive(1'b1, 2);
    check("false_start_busy_high", busy_out, 1);
    drive(1'b1, 10);
    check("false_start_busy_low", busy_out, 0);
    expect_word(1'b0, 8'hA5);
    send(8'hA5, 1'b1, 8, -1);
    expect_word(1'b1, 8'hA5);
    send(8'h3C, 1'b0, 16, -1);
    drive(1'b1, 16);
    check("ferr_recovered_idle", busy_out, 0);
    check("ferr_data_kept", data_out, 8'hA5);
    expect_word(1'b0, 8'h5A);
    send(8'h5A, 1'b1, 8, -1);
    drive(1'b1, 8);
    drain("drain_ferr");
    expect_word(1'b0, 8'h00);
    expect_word(1'b0, 8'hFF);
    send(8'h00, 1'b1, 8, -1);
    send(8'hFF, 1'b1, 8, -1);
    drive(1'b1, 8);
    drain("drain_b2b");
    check("b2b_gap_cycles", last_v - prev_v, 80);
    drive(1'b0, 8);
    for (int k = 0; k < 4; k++) drive(k == 0, 8);
    drive(1'b0, 3);
    check("midframe_busy", busy_out, 1);
    rst_in = 1'b1;
    rx_in = 1'b1;
    #1;
    check("midrst_data", data_out, 0);
    check("midrst_busy", busy_out, 0);
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    drive(1'b1, 100);
    check("after_rst_busy", busy_out, 0);
    check("after_rst_data", data_out, 0);
    expect_word(1'b0, 8'h81);
    send(8'h81, 1'b1, 8, -1);
    drive(1'b1, 8);
    drain("drain_81");
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h08;
`endif
    expect_word(1'b0, glitch_exp);
    send(8'h00, 1'b1, 8, 3);
    drive(1'b1, 8);
    drain("drain_glitch");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
